// File: rtl/pipeline_halt_monitor.sv
// End-of-program detector beside the IF stage: freezes fetch on the halt sentinel,
// waits for the older instructions to drain, then raises end_program.
module pipeline_halt_monitor #(
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES   = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic        if_valid,
  input  logic        if_stall,
  input  logic        if_flush,
  input  logic        wb_valid,
  output logic        halt_fetch,
  output logic        end_program,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] DRAIN_INIT = 32'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic        end_q, end_d;
  logic        timeout_q, timeout_d;

  logic detect;
  logic watchdog;

  // A stalled sentinel is not consumed; it is seen again once the stall clears.
  assign detect   = if_valid & ~if_flush & ~if_stall & (if_instr == HALT_INSTR);
  assign watchdog = (state_q != DONE) & (cycle_q == MAX_CYCLES - 32'd1);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    end_d     = end_q;
    timeout_d = timeout_q;

    if (state_q != DONE) begin
      cycle_d = cycle_q + 32'd1;
      if (wb_valid) begin
        instret_d = instret_q + 32'd1;
      end
    end

    case (state_q)
      RUN: begin
        if (watchdog) begin
          state_d   = DONE;
          end_d     = 1'b1;
          timeout_d = 1'b1;
        end else if (detect) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = DONE;
            end_d   = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        // A repeated sentinel here is the frozen PC refetching it; it is ignored.
        if (watchdog) begin
          state_d   = DONE;
          end_d     = 1'b1;
          timeout_d = 1'b1;
        end else if (!if_stall) begin
          drain_d = drain_q - 32'd1;
          if (drain_q == 32'd1) begin
            state_d = DONE;
            end_d   = 1'b1;
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      drain_q   <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      end_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      end_q     <= end_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational so the PC is held in the very cycle the sentinel is in IF.
  assign halt_fetch    = (state_q != RUN) | detect;
  assign end_program   = end_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_pipeline_halt_monitor.sv
// Directed bench for pipeline_halt_monitor: nominal halt, drain stalls, flushed/stalled
// sentinels, watchdog, reset mid-drain and sentinel colliding with the watchdog.
module tb_pipeline_halt_monitor;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] I1   = 32'h0050_0093;
  localparam logic [31:0] I2   = 32'h0010_8113;
  localparam logic [31:0] I3   = 32'h0010_01B3;
  localparam logic [31:0] I4   = 32'h0010_8213;

  logic        clk;
  logic        reset;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_stall;
  logic        if_flush;
  logic        wb_valid;
  logic        halt_fetch;
  logic        end_program;
  logic        timeout;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  int checks = 0;
  int errors = 0;

  pipeline_halt_monitor #(
    .HALT_INSTR  (HALT),
    .DRAIN_CYCLES(4),
    .MAX_CYCLES  (32'd20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .if_stall     (if_stall),
    .if_flush     (if_flush),
    .wb_valid     (wb_valid),
    .halt_fetch   (halt_fetch),
    .end_program  (end_program),
    .timeout      (timeout),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic stall,
                       input logic flush, input logic wb);
    if_instr = instr;
    if_valid = valid;
    if_stall = stall;
    if_flush = flush;
    wb_valid = wb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [31:0] instr, input logic valid, input logic stall,
                     input logic flush, input logic wb);
    drive(instr, valid, stall, flush, wb);
    tick();
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic hf, input logic ep, input logic to,
                           input logic [31:0] cc, input logic [31:0] ir);
    check({tag, ".halt_fetch"}, 32'(halt_fetch), 32'(hf));
    check({tag, ".end_program"}, 32'(end_program), 32'(ep));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
    check({tag, ".cycle_count"}, cycle_count, cc);
    check({tag, ".instret_count"}, instret_count, ir);
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    check_all("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Nominal run: sentinel fetched in cycle 5, done at cycle 9
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nom.pre_halt_fetch", 32'(halt_fetch), 32'd0);
    drive(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("nom.halt_comb", 32'(halt_fetch), 32'd1);
    tick();
    check_all("nom.e5", 1'b1, 1'b0, 1'b0, 32'd5, 32'd1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("nom.e8", 1'b1, 1'b0, 1'b0, 32'd8, 32'd4);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("nom.done", 1'b1, 1'b1, 1'b0, 32'd9, 32'd4);
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("nom.frozen", 1'b1, 1'b1, 1'b0, 32'd9, 32'd4);

    // Two stalled cycles inside the drain delay end_program by two
    do_reset();
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I4, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("stall.e9", 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("stall.e10", 1'b1, 1'b0, 1'b0, 32'd10, 32'd4);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("stall.done", 1'b1, 1'b1, 1'b0, 32'd11, 32'd4);

    // Flushed and stalled sentinels are ignored; the next clean one terminates
    do_reset();
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(HALT, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("flush.halt_comb", 32'(halt_fetch), 32'd0);
    tick();
    drive(I2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("flush.still_run", 32'(halt_fetch), 32'd0);
    tick();
    drive(HALT, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("flush.stalled_sentinel", 32'(halt_fetch), 32'd0);
    tick();
    check_all("flush.e4", 1'b0, 1'b0, 1'b0, 32'd4, 32'd0);
    drive(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("flush.stall_cleared", 32'(halt_fetch), 32'd1);
    tick();
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    check("flush.e8_not_done", 32'(end_program), 32'd0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("flush.done", 1'b1, 1'b1, 1'b0, 32'd9, 32'd2);

    // Watchdog: no sentinel, MAX_CYCLES = 20
    do_reset();
    for (int i = 0; i < 19; i++) cyc(I1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("wd.e19", 1'b0, 1'b0, 1'b0, 32'd19, 32'd19);
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("wd.fire", 1'b1, 1'b1, 1'b1, 32'd20, 32'd20);
    for (int i = 0; i < 3; i++) cyc(I1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("wd.frozen", 1'b1, 1'b1, 1'b1, 32'd20, 32'd20);

    // Reset two cycles into the drain, then a fresh program from zero
    do_reset();
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I4, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst.in_drain", 32'(halt_fetch), 32'd1);
    do_reset();
    check_all("rst.cleared", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc(I1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I3, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(I4, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    // The retire on the edge that enters DONE is still counted
    cyc(HALT, 1'b1, 1'b0, 1'b0, 1'b1);
    check_all("rst.fresh_done", 1'b1, 1'b1, 1'b0, 32'd9, 32'd4);

    // Sentinel detected on the same edge the watchdog fires
    do_reset();
    for (int i = 0; i < 19; i++) cyc(I1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(HALT, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("sim.halt_comb", 32'(halt_fetch), 32'd1);
    tick();
    check_all("sim.done", 1'b1, 1'b1, 1'b1, 32'd20, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
